rx_gather_fifo: RTL and testbench

Receive-side byte buffer for the UART. The RX deserializer pushes one byte per cycle. The bus side pops 1 to 4 bytes in a single access. Storage is four byte-wide interleaved banks, one per byte lane, so an unaligned multi-byte pop reads every lane in parallel in one cycle. This block is the read-wide, write-narrow counterpart of the TX-side byte-gather FIFO. It sits between the UART receiver and the peripheral register interface.

---
 rtl/rx_gather_fifo.sv | 116 +++++++++++
 tb/tb_rx_gather_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_gather_fifo.sv
// Receive byte FIFO: one byte pushed per cycle, 1..LaneCount bytes popped per access from interleaved lane banks.
// Optional sticky overrun flag is built when HIPPO_RX_OVERRUN_EN is defined.
module rx_gather_fifo #(
   parameter int DepthBytes = 64,
   parameter int LaneCount  = 4,
   parameter int LevelWidth = $clog2(DepthBytes) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_valid,
   input  logic [7:0]             push_data,
   output logic                   push_ready,
   input  logic                   pop_req,
   input  logic [2:0]             pop_width,
   output logic                   pop_accept,
   output logic                   pop_valid,
   output logic [8*LaneCount-1:0] pop_data,
   output logic [LevelWidth-1:0]  level,
   output logic                   overrun,
   input  logic                   overrun_clear
);

   localparam int PtrWidth  = $clog2(DepthBytes);
   localparam int RowCount  = DepthBytes / LaneCount;
   localparam int RowWidth  = (RowCount > 1) ? $clog2(RowCount) : 1;
   localparam int LaneWidth = (LaneCount > 1) ? $clog2(LaneCount) : 1;

   logic [7:0]           bank [LaneCount][RowCount];
   logic [PtrWidth-1:0]  wr_ptr;
   logic [PtrWidth-1:0]  rd_ptr;
   logic [LaneWidth-1:0] wr_lane;
   logic [RowWidth-1:0]  wr_row;
   logic [LaneWidth-1:0] rd_lane;
   logic [RowWidth-1:0]  rd_row;
   logic [RowWidth-1:0]  lane_row  [LaneCount];
   logic [7:0]           lane_byte [LaneCount];
   logic [8*LaneCount-1:0] data_next;
   logic                 push_fire;
   logic                 width_ok;

   assign wr_lane = LaneWidth'(wr_ptr % PtrWidth'(LaneCount));
   assign wr_row  = RowWidth'(wr_ptr / PtrWidth'(LaneCount));
   assign rd_lane = LaneWidth'(rd_ptr % PtrWidth'(LaneCount));
   assign rd_row  = RowWidth'(rd_ptr / PtrWidth'(LaneCount));

   assign push_ready = (level != LevelWidth'(DepthBytes));
   assign push_fire  = push_valid && push_ready;
   assign width_ok   = (pop_width != 3'd0) && (int'(pop_width) <= LaneCount);
   assign pop_accept = pop_req && width_ok && (level >= LevelWidth'(pop_width));

   // Lanes below the starting lane belong to the next row of the access.
   always_comb begin
      for (int l = 0; l < LaneCount; l++) begin
         lane_row[l] = rd_row;
         if (l < int'(rd_lane)) begin
            lane_row[l] = (int'(rd_row) == RowCount - 1) ? '0 : rd_row + RowWidth'(1);
         end
         lane_byte[l] = bank[l][lane_row[l]];
      end
   end

   // Oldest byte lands in the most significant valid slot; unused slots are zero.
   always_comb begin
      data_next = '0;
      for (int j = 0; j < LaneCount; j++) begin
         if (j < int'(pop_width)) begin
            data_next[8*j +: 8] =
               lane_byte[LaneWidth'((int'(rd_lane) + int'(pop_width) - 1 - j) % LaneCount)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) begin
         bank[wr_lane][wr_row] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pop_valid <= 1'b0;
         pop_data  <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + PtrWidth'(1);
         end
         if (pop_accept) begin
            rd_ptr   <= rd_ptr + PtrWidth'(pop_width);
            pop_data <= data_next;
         end
         level     <= level + LevelWidth'(push_fire)
                      - (pop_accept ? LevelWidth'(pop_width) : LevelWidth'(0));
         pop_valid <= pop_accept;
      end
   end

`ifdef HIPPO_RX_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (overrun_clear) begin
         overrun <= 1'b0;
      end else if (push_valid && !push_ready) begin
         overrun <= 1'b1;
      end
   end
`else
   logic unused_overrun_clear;
   assign unused_overrun_clear = overrun_clear;
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rx_gather_fifo.sv
// Bench for rx_gather_fifo: directed vector table, corner sequences and random traffic
// compared against a byte-queue reference model.
module tb_rx_gather_fifo;

   localparam int DEPTH = 64;
   localparam int LANES = 4;

   logic        clk;
   logic        reset;
   logic        push_valid;
   logic [7:0]  push_data;
   logic        push_ready;
   logic        pop_req;
   logic [2:0]  pop_width;
   logic        pop_accept;
   logic        pop_valid;
   logic [31:0] pop_data;
   logic [6:0]  level;
   logic        overrun;
   logic        overrun_clear;

   rx_gather_fifo dut (
      .clk           (clk),
      .reset         (reset),
      .push_valid    (push_valid),
      .push_data     (push_data),
      .push_ready    (push_ready),
      .pop_req       (pop_req),
      .pop_width     (pop_width),
      .pop_accept    (pop_accept),
      .pop_valid     (pop_valid),
      .pop_data      (pop_data),
      .level         (level),
      .overrun       (overrun),
      .overrun_clear (overrun_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [7:0]  pd;
      logic        pr;
      logic [2:0]  pw;
      logic        e_acc;
      logic [6:0]  e_lvl;
      logic        e_valid;
      logic [31:0] e_data;
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  model_q[$];
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ovr;
   logic        acc_seen;
   int          rd_count;
   int          checks;
   int          failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic pv, input logic [7:0] pd, input logic pr,
                               input logic [2:0] pw, input logic e_acc, input logic [6:0] e_lvl,
                               input logic e_valid, input logic [31:0] e_data);
      vec_t v;
      v.pv = pv; v.pd = pd; v.pr = pr; v.pw = pw;
      v.e_acc = e_acc; v.e_lvl = e_lvl; v.e_valid = e_valid; v.e_data = e_data;
      vecs.push_back(v);
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic drive_cycle(input logic pv, input logic [7:0] pd, input logic pr,
                              input logic [2:0] pw, input logic clr);
      logic        exp_acc;
      logic        was_full;
      logic [31:0] d;
      push_valid    = pv;
      push_data     = pd;
      pop_req       = pr;
      pop_width     = pw;
      overrun_clear = clr;
      #1;
      exp_acc = pr && (pw >= 3'd1) && (int'(pw) <= LANES) && (model_q.size() >= int'(pw));
      was_full = (model_q.size() == DEPTH);
      acc_seen = pop_accept;
      chk("pop_accept", 32'(pop_accept), 32'(exp_acc));
      chk("push_ready", 32'(push_ready), 32'(!was_full));
      @(posedge clk);
      if (exp_acc) begin
         d = '0;
         for (int i = 0; i < int'(pw); i++) d = (d << 8) | 32'(model_q.pop_front());
         m_data = d;
         rd_count += int'(pw);
      end
      m_valid = exp_acc;
      if (pv && !was_full) model_q.push_back(pd);
`ifdef HIPPO_RX_OVERRUN_EN
      if (clr) m_ovr = 1'b0;
      else if (pv && was_full) m_ovr = 1'b1;
`endif
      #1;
      chk("pop_valid", 32'(pop_valid), 32'(m_valid));
      chk("pop_data", pop_data, m_data);
      chk("level", 32'(level), 32'(model_q.size()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      @(negedge clk);
   endtask

   task automatic reset_dut(input logic with_pop);
      reset         = 1'b1;
      push_valid    = 1'b0;
      push_data     = 8'h00;
      pop_req       = with_pop;
      pop_width     = 3'd1;
      overrun_clear = 1'b0;
      #1;
      if (with_pop) chk("reset_pop_accept", 32'(pop_accept), 32'(model_q.size() >= 1));
      @(posedge clk);
      model_q.delete();
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; rd_count = 0;
      #1;
      reset   = 1'b0;
      pop_req = 1'b0;
      #1;
      chk("reset_pop_valid", 32'(pop_valid), 32'h0);
      chk("reset_level", 32'(level), 32'h0);
      chk("reset_pop_data", pop_data, 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
      chk("reset_push_ready", 32'(push_ready), 32'h1);
      chk("reset_pop_accept_after", 32'(pop_accept), 32'h0);
      @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0; rd_count = 0;
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; acc_seen = 1'b0;
      reset = 1'b1; push_valid = 1'b0; push_data = 8'h00;
      pop_req = 1'b0; pop_width = 3'd0; overrun_clear = 1'b0;
      @(negedge clk);
      reset_dut(1'b0);

      // Single pop, unaligned wide pop, simultaneous push/pop, illegal widths.
      add(1, 8'h41, 0, 0, 0, 1, 0, 32'h0);
      add(1, 8'h42, 0, 0, 0, 2, 0, 32'h0);
      add(0, 8'h00, 1, 2, 1, 0, 1, 32'h00004142);
      add(0, 8'h00, 0, 0, 0, 0, 0, 32'h00004142);
      for (int i = 1; i <= 6; i++) add(1, 8'(i), 0, 0, 0, 7'(i), 0, 32'h00004142);
      add(0, 8'h00, 1, 1, 1, 5, 1, 32'h00000001);
      add(0, 8'h00, 1, 4, 1, 1, 1, 32'h02030405);
      add(0, 8'h00, 1, 1, 1, 0, 1, 32'h00000006);
      add(1, 8'h11, 0, 0, 0, 1, 0, 32'h00000006);
      add(1, 8'h22, 0, 0, 0, 2, 0, 32'h00000006);
      add(1, 8'h33, 0, 0, 0, 3, 0, 32'h00000006);
      add(1, 8'h55, 1, 3, 1, 1, 1, 32'h00112233);
      add(0, 8'h00, 1, 1, 1, 0, 1, 32'h00000055);
      add(1, 8'hAA, 0, 0, 0, 1, 0, 32'h00000055);
      add(1, 8'hBB, 0, 0, 0, 2, 0, 32'h00000055);
      add(0, 8'h00, 1, 0, 0, 2, 0, 32'h00000055);
      add(0, 8'h00, 1, 5, 0, 2, 0, 32'h00000055);
      add(0, 8'h00, 1, 3, 0, 2, 0, 32'h00000055);
      add(0, 8'h00, 1, 2, 1, 0, 1, 32'h0000AABB);
      for (int k = 0; k < vecs.size(); k++) begin
         drive_cycle(vecs[k].pv, vecs[k].pd, vecs[k].pr, vecs[k].pw, 1'b0);
         chk($sformatf("vec%0d_accept", k), 32'(acc_seen), 32'(vecs[k].e_acc));
         chk($sformatf("vec%0d_level", k), 32'(level), 32'(vecs[k].e_lvl));
         chk($sformatf("vec%0d_valid", k), 32'(pop_valid), 32'(vecs[k].e_valid));
         chk($sformatf("vec%0d_data", k), pop_data, vecs[k].e_data);
      end

      // Walk the read pointer to 62 so a 4-byte pop spans the last row into row 0.
      for (int g = 0; g < 70 && (rd_count % DEPTH) != 62; g++) begin
         drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 3'd0, 1'b0);
         drive_cycle(1'b0, 8'h00, 1'b1, 3'd1, 1'b0);
      end
      chk("wrap_rd_pos", 32'(rd_count % DEPTH), 32'd62);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 3'd0, 1'b0);
      drive_cycle(1'b0, 8'h00, 1'b1, 3'd4, 1'b0);
      chk("wrap_data", pop_data, 32'hA0A1A2A3);
      chk("wrap_level", 32'(level), 32'd0);

      // Fill, overflow, overflow with a concurrent pop, drain, clear.
      for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'($urandom_range(0, 254)), 1'b0, 3'd0, 1'b0);
      chk("full_push_ready", 32'(push_ready), 32'h0);
      chk("full_level", 32'(level), 32'd64);
      drive_cycle(1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
      chk("overflow_level", 32'(level), 32'd64);
`ifdef HIPPO_RX_OVERRUN_EN
      chk("overflow_flag", 32'(overrun), 32'h1);
`else
      chk("overflow_flag", 32'(overrun), 32'h0);
`endif
      drive_cycle(1'b1, 8'hFF, 1'b1, 3'd4, 1'b0);
      chk("overflow_pop_level", 32'(level), 32'd60);
      for (int i = 0; i < 15; i++) begin
         drive_cycle(1'b0, 8'h00, 1'b1, 3'd4, 1'b0);
         for (int b = 0; b < 4; b++) chk("no_ff_byte", 32'(pop_data[8*b +: 8] == 8'hFF), 32'h0);
      end
      drive_cycle(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
      chk("overrun_cleared", 32'(overrun), 32'h0);

      // Reset while a pop is being accepted.
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(i + 7), 1'b0, 3'd0, 1'b0);
      reset_dut(1'b1);

      // Random traffic with alternating fill pressure.
      for (int k = 0; k < 800; k++) begin
         int bias;
         bias = ((k / 100) % 2 == 1) ? 90 : 35;
         if ($urandom_range(0, 299) == 0) begin
            reset_dut(1'($urandom_range(0, 1)));
         end else begin
            drive_cycle(1'($urandom_range(0, 99) < bias), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 99) < 60), 3'($urandom_range(0, 5)),
                        1'($urandom_range(0, 19) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
